// File: rtl/dvfs_controller.sv
`default_nettype none
// ============================================================================
// Module  : dvfs_controller
// Purpose : Utilization-driven DVFS sequencer: voltage up before freq, freq down before voltage.
// Rev     : 1.0 - initial release
// ============================================================================
module dvfs_controller #(
    parameter int WINDOW   = 256,
    parameter int UP_TH    = 192,
    parameter int DN_TH    = 64,
    parameter int V_SETTLE = 64,
    parameter int DWELL    = 512
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      busy,
    input  logic                      force_en,
    input  logic [1:0]                force_level,
    input  logic                      sw_ack,
    output logic [1:0]                freq_sel,
    output logic [1:0]                vdd_level,
    output logic                      sw_req,
    output logic                      in_transition,
    output logic [$clog2(WINDOW):0]   util_last
);

    localparam int WW   = $clog2(WINDOW);
    localparam int CW   = WW + 1;
    localparam int TMAX = (V_SETTLE > DWELL) ? V_SETTLE : DWELL;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);
    localparam logic [CW-1:0] WIN_FULL    = CW'(WINDOW);
    localparam logic [CW-1:0] UP_TH_C     = CW'(UP_TH);
    localparam logic [CW-1:0] DN_TH_C     = CW'(DN_TH);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(V_SETTLE - 1);
    localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL - 1);

    typedef enum logic [2:0] {
        ST_MONITOR  = 3'd0,
        ST_V_UP     = 3'd1,
        ST_F_SWITCH = 3'd2,
        ST_V_DOWN   = 3'd3,
        ST_DWELL    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    freq_q, freq_d;
    logic [1:0]    vdd_q, vdd_d;
    logic [1:0]    target_q, target_d;
    logic          sw_req_q, sw_req_d;
    logic [CW-1:0] util_q, util_d;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic [CW-1:0] busy_next;
    logic [1:0]    dec_tgt;

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        vdd_d      = vdd_q;
        target_d   = target_q;
        sw_req_d   = sw_req_q;
        util_d     = util_q;
        win_d      = '0;
        busy_cnt_d = '0;
        tmr_d      = tmr_q + TW'(1);
        dec_tgt    = freq_q;
        busy_next  = (busy_cnt_q == WIN_FULL) ? busy_cnt_q : busy_cnt_q + CW'(busy);

        case (state_q)
            ST_MONITOR: begin
                tmr_d      = '0;
                win_d      = win_q + WW'(1);
                busy_cnt_d = busy_next;
                if (win_q == WIN_LAST) begin
                    win_d      = '0;
                    busy_cnt_d = '0;
                    util_d     = busy_next;
                    if (busy_next >= UP_TH_C && freq_q != 2'd0) begin
                        dec_tgt = freq_q - 2'd1;
                    end else if (busy_next <= DN_TH_C && freq_q != 2'd3) begin
                        dec_tgt = freq_q + 2'd1;
                    end
                end
                // Manual override wins over any window verdict in the same cycle.
                if (force_en) begin
                    dec_tgt = force_level;
                end
                target_d = dec_tgt;
                if (dec_tgt < freq_q) begin
                    state_d = ST_V_UP;
                    vdd_d   = 2'd3 - dec_tgt;
                end else if (dec_tgt > freq_q) begin
                    state_d  = ST_F_SWITCH;
                    freq_d   = dec_tgt;
                    sw_req_d = 1'b1;
                end
            end
            ST_V_UP: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d  = ST_F_SWITCH;
                    freq_d   = target_q;
                    sw_req_d = 1'b1;
                    tmr_d    = '0;
                end
            end
            ST_F_SWITCH: begin
                tmr_d = '0;
                if (sw_req_q && sw_ack) begin
                    sw_req_d = 1'b0;
                    // Surplus voltage means this was a slow-down; trim the rail next.
                    if (vdd_q != 2'd3 - freq_q) begin
                        state_d = ST_V_DOWN;
                        vdd_d   = 2'd3 - freq_q;
                    end else begin
                        state_d = ST_DWELL;
                    end
                end
            end
            ST_V_DOWN: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_DWELL;
                    tmr_d   = '0;
                end
            end
            ST_DWELL: begin
                if (tmr_q == DWELL_LAST) begin
                    state_d = ST_MONITOR;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = ST_MONITOR;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_MONITOR;
            freq_q     <= 2'd0;
            vdd_q      <= 2'd3;
            target_q   <= 2'd0;
            sw_req_q   <= 1'b0;
            util_q     <= '0;
            win_q      <= '0;
            busy_cnt_q <= '0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            vdd_q      <= vdd_d;
            target_q   <= target_d;
            sw_req_q   <= sw_req_d;
            util_q     <= util_d;
            win_q      <= win_d;
            busy_cnt_q <= busy_cnt_d;
            tmr_q      <= tmr_d;
        end
    end

    assign freq_sel      = freq_q;
    assign vdd_level     = vdd_q;
    assign sw_req        = sw_req_q;
    assign in_transition = (state_q != ST_MONITOR);
    assign util_last     = util_q;

endmodule
`default_nettype wire

// File: tb/tb_dvfs_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_dvfs_controller
// Purpose : Randomized window/force traffic against a transaction-level DVFS model.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dvfs_controller;

    localparam int WINDOW   = 16;
    localparam int UP_TH    = 12;
    localparam int DN_TH    = 4;
    localparam int V_SETTLE = 8;
    localparam int DWELL    = 32;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       busy = 1'b0;
    logic       force_en = 1'b0;
    logic [1:0] force_level = 2'd0;
    logic       sw_ack = 1'b0;
    logic [1:0] freq_sel;
    logic [1:0] vdd_level;
    logic       sw_req;
    logic       in_transition;
    logic [4:0] util_last;

    int total = 0;
    int bad   = 0;
    logic [1:0] m_freq = 2'd0;
    logic [1:0] m_vdd  = 2'd3;

    dvfs_controller #(
        .WINDOW(WINDOW), .UP_TH(UP_TH), .DN_TH(DN_TH), .V_SETTLE(V_SETTLE), .DWELL(DWELL)
    ) dut (
        .clk_in(clk_in), .rst(rst), .busy(busy), .force_en(force_en),
        .force_level(force_level), .sw_ack(sw_ack), .freq_sel(freq_sel),
        .vdd_level(vdd_level), .sw_req(sw_req), .in_transition(in_transition),
        .util_last(util_last)
    );

    always #5 clk_in = ~clk_in;

    // Voltage must always support the running frequency.
    always @(negedge clk_in) begin
        total++;
        if (vdd_level < 2'd3 - freq_sel) begin
            bad++;
            $display("FAIL vdd_invariant: vdd_level=%0d freq_sel=%0d need vdd_level>=%0d",
                     vdd_level, freq_sel, 2'd3 - freq_sel);
        end
    end

    // Called on the first negedge after the decision edge; completes the whole sequence.
    task automatic run_transition(input logic [1:0] tgt);
        logic [1:0] f0;
        bit up;
        int d, hold;
        f0 = m_freq;
        up = (tgt < f0);
        total++;
        if (in_transition !== 1'b1) begin
            bad++; $display("FAIL tr_entry: in_transition=%0b expected 1", in_transition);
        end
        if (up) begin
            total++;
            if (vdd_level !== 2'd3 - tgt || freq_sel !== f0 || sw_req !== 1'b0) begin
                bad++;
                $display("FAIL vup_entry: vdd=%0d freq=%0d sw_req=%0b expected vdd=%0d freq=%0d sw_req=0",
                         vdd_level, freq_sel, sw_req, 2'd3 - tgt, f0);
            end
            for (int i = 1; i < V_SETTLE; i++) begin
                sw_ack = 1'($urandom_range(0, 1));
                force_en = 1'($urandom_range(0, 1));
                force_level = 2'($urandom_range(0, 3));
                @(negedge clk_in);
                total++;
                if (freq_sel !== f0 || sw_req !== 1'b0) begin
                    bad++;
                    $display("FAIL vup_wait: cycle %0d freq=%0d sw_req=%0b expected freq=%0d sw_req=0",
                             i, freq_sel, sw_req, f0);
                end
            end
            sw_ack = 1'($urandom_range(0, 1));
            @(negedge clk_in);
        end
        total++;
        if (freq_sel !== tgt || sw_req !== 1'b1) begin
            bad++;
            $display("FAIL fsw_entry: freq=%0d sw_req=%0b expected freq=%0d sw_req=1", freq_sel, sw_req, tgt);
        end
        d = $urandom_range(0, 4);
        for (int i = 0; i < d; i++) begin
            sw_ack = 1'b0;
            force_level = 2'($urandom_range(0, 3));
            @(negedge clk_in);
            total++;
            if (freq_sel !== tgt || sw_req !== 1'b1) begin
                bad++;
                $display("FAIL fsw_hold: freq=%0d sw_req=%0b expected freq=%0d sw_req=1", freq_sel, sw_req, tgt);
            end
        end
        sw_ack = 1'b1;
        @(negedge clk_in);
        sw_ack = 1'b0;
        total++;
        if (sw_req !== 1'b0 || freq_sel !== tgt || vdd_level !== 2'd3 - tgt) begin
            bad++;
            $display("FAIL post_ack: sw_req=%0b freq=%0d vdd=%0d expected sw_req=0 freq=%0d vdd=%0d",
                     sw_req, freq_sel, vdd_level, tgt, 2'd3 - tgt);
        end
        m_freq = tgt;
        m_vdd  = 2'd3 - tgt;
        hold = (up ? 0 : V_SETTLE) + DWELL;
        for (int i = 1; i < hold; i++) begin
            sw_ack = 1'($urandom_range(0, 1));
            force_en = 1'($urandom_range(0, 1));
            force_level = 2'($urandom_range(0, 3));
            @(negedge clk_in);
            total++;
            if (in_transition !== 1'b1 || freq_sel !== m_freq || vdd_level !== m_vdd || sw_req !== 1'b0) begin
                bad++;
                $display("FAIL tr_hold: cycle %0d it=%0b freq=%0d vdd=%0d sw_req=%0b expected it=1 freq=%0d vdd=%0d sw_req=0",
                         i, in_transition, freq_sel, vdd_level, sw_req, m_freq, m_vdd);
            end
        end
        sw_ack = 1'b0;
        force_en = 1'b0;
        @(negedge clk_in);
        total++;
        if (in_transition !== 1'b0 || freq_sel !== m_freq || vdd_level !== m_vdd) begin
            bad++;
            $display("FAIL tr_exit: it=%0b freq=%0d vdd=%0d expected it=0 freq=%0d vdd=%0d",
                     in_transition, freq_sel, vdd_level, m_freq, m_vdd);
        end
    endtask

    // One full window starting at a window-aligned negedge; flvl>=0 forces on the last cycle.
    task automatic test_window(input int k, input bit exact, input int flvl);
        int cnt;
        bit b;
        logic [1:0] tgt;
        cnt = 0;
        for (int i = 0; i < WINDOW; i++) begin
            b = exact ? (i < k) : ($urandom_range(0, 15) < k);
            busy = b;
            cnt += int'(b);
            if (flvl >= 0 && i == WINDOW - 1) begin
                force_en = 1'b1;
                force_level = 2'(flvl);
            end
            @(negedge clk_in);
        end
        total++;
        if (util_last !== 5'(cnt)) begin
            bad++; $display("FAIL util_last: got %0d expected %0d", util_last, cnt);
        end
        tgt = m_freq;
        if (cnt >= UP_TH && m_freq > 0) tgt = m_freq - 2'd1;
        else if (cnt <= DN_TH && m_freq < 3) tgt = m_freq + 2'd1;
        if (flvl >= 0) tgt = 2'(flvl);
        if (tgt == m_freq) begin
            total++;
            if (in_transition !== 1'b0 || freq_sel !== m_freq || vdd_level !== m_vdd || sw_req !== 1'b0) begin
                bad++;
                $display("FAIL no_change: it=%0b freq=%0d vdd=%0d sw_req=%0b expected it=0 freq=%0d vdd=%0d sw_req=0",
                         in_transition, freq_sel, vdd_level, sw_req, m_freq, m_vdd);
            end
        end else begin
            run_transition(tgt);
        end
    endtask

    task automatic test_force(input logic [1:0] lvl);
        force_en = 1'b1;
        force_level = lvl;
        busy = 1'($urandom_range(0, 1));
        @(negedge clk_in);
        run_transition(lvl);
    endtask

    task automatic test_reset;
        @(negedge clk_in);
        total++;
        if (freq_sel !== 2'd0 || vdd_level !== 2'd3 || sw_req !== 1'b0 || in_transition !== 1'b0 || util_last !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: freq=%0d vdd=%0d sw_req=%0b it=%0b util=%0d expected 0/3/0/0/0",
                     freq_sel, vdd_level, sw_req, in_transition, util_last);
        end
        rst = 1'b0;
        m_freq = 2'd0;
        m_vdd = 2'd3;
    endtask

    task automatic test_slow_down_idle;
        test_window(0, 1'b1, -1);
    endtask

    task automatic test_speed_up_full;
        test_window(0, 1'b1, -1);
        test_window(16, 1'b1, -1);
    endtask

    task automatic test_between_thresholds;
        test_window(8, 1'b1, -1);
    endtask

    task automatic test_thresholds;
        test_window(5, 1'b1, -1);
        test_window(11, 1'b1, -1);
        test_window(12, 1'b1, -1);
        test_window(16, 1'b1, -1);
        test_window(4, 1'b1, -1);
        test_window(12, 1'b1, -1);
    endtask

    task automatic test_force_override;
        test_force(2'd3);
        test_window(0, 1'b1, -1);
        test_force(2'd0);
    endtask

    task automatic test_force_precedence;
        test_window(0, 1'b1, 2);
    endtask

    task automatic test_random;
        int lvl;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                lvl = $urandom_range(0, 3);
                if (2'(lvl) == m_freq) lvl = (lvl + 1) % 4;
                test_force(2'(lvl));
            end else begin
                test_window($urandom_range(0, 16), 1'b0, -1);
            end
        end
    endtask

    task automatic test_ack_withheld_reset;
        logic [1:0] tgt;
        if (m_freq == 2'd3) test_force(2'd2);
        tgt = m_freq + 2'd1;
        for (int i = 0; i < WINDOW; i++) begin
            busy = (i < 3);
            @(negedge clk_in);
        end
        sw_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (sw_req !== 1'b1 || freq_sel !== tgt || util_last !== 5'd3) begin
                bad++;
                $display("FAIL ack_wait: cycle %0d sw_req=%0b freq=%0d util=%0d expected sw_req=1 freq=%0d util=3",
                         i, sw_req, freq_sel, util_last, tgt);
            end
            @(negedge clk_in);
        end
        #2 rst = 1'b1;
        #2;
        total++;
        if (freq_sel !== 2'd0 || vdd_level !== 2'd3 || sw_req !== 1'b0 || in_transition !== 1'b0 || util_last !== 5'd0) begin
            bad++;
            $display("FAIL async_rst: freq=%0d vdd=%0d sw_req=%0b it=%0b util=%0d expected 0/3/0/0/0",
                     freq_sel, vdd_level, sw_req, in_transition, util_last);
        end
        @(negedge clk_in);
        rst = 1'b0;
        m_freq = 2'd0;
        m_vdd = 2'd3;
        test_window(8, 1'b1, -1);
    endtask

    initial begin
        test_reset;
        test_slow_down_idle;
        test_speed_up_full;
        test_between_thresholds;
        test_thresholds;
        test_force_override;
        test_force_precedence;
        test_random;
        test_ack_withheld_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvfs_controller.md
DVFS_CONTROLLER -- requirements
Module: dvfs_controller

Interface
REQ-001 SHALL have parameter WINDOW, default 256: utilization sample window in cycles; power of two, at least 4.
REQ-002 SHALL have parameter UP_TH, default 192: busy-cycle count at or above which the controller steps up one frequency level.
REQ-003 SHALL have parameter DN_TH, default 64: busy-cycle count at or below which the controller steps down one level; DN_TH < UP_TH.
REQ-004 SHALL have parameter V_SETTLE, default 64: regulator settle wait in cycles, at least 1.
REQ-005 SHALL have parameter DWELL, default 512: minimum hold time after a transition, in cycles, at least 1.
REQ-006 SHALL have port clk_in, input, 1 bit: single clock, 100 MHz reference domain.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port busy, input, 1 bit: workload active this cycle.
REQ-009 SHALL have port force_en, input, 1 bit: manual level override.
REQ-010 SHALL have port force_level, input, 2 bits: override target freq_sel.
REQ-011 SHALL have port sw_ack, input, 1 bit: clock switch completed.
REQ-012 SHALL have port freq_sel, output, 2 bits: 0=100 MHz, 1=50, 2=25, 3=12.5 MHz.
REQ-013 SHALL have port vdd_level, output, 2 bits: regulator code; steady state is 3-freq_sel.
REQ-014 SHALL have port sw_req, output, 1 bit: clock switch request.
REQ-015 SHALL have port in_transition, output, 1 bit: high whenever state is not MONITOR.
REQ-016 SHALL have port util_last, output, log2(WINDOW)+1 bits: busy count of the last completed window.

Function
REQ-017 SHALL implement FSM states MONITOR, V_UP, F_SWITCH, V_DOWN, DWELL.
REQ-018 SHALL, in MONITOR only, count busy cycles over WINDOW consecutive cycles; a busy on the window's last cycle counts; the counter saturates at WINDOW.
REQ-019 SHALL, at window end, load util_last and clear the counters the next cycle.
REQ-020 SHALL set target to freq_sel-1 when the count is at least UP_TH and freq_sel>0, and to freq_sel+1 when the count is at most DN_TH and freq_sel<3.
REQ-021 SHALL otherwise make no decision; at most one level step per window.
REQ-022 SHALL, when force_en=1 in MONITOR, ignore the window and use target=force_level, sampled every cycle; multi-level steps are allowed and force takes precedence over a window decision in the same cycle.
REQ-023 SHALL, for target==freq_sel, stay in MONITOR with no output change.
REQ-024 SHALL, for target<freq_sel (speed-up), go MONITOR->V_UP, set vdd_level=3-target on entry, and wait V_SETTLE cycles before F_SWITCH.
REQ-025 SHALL, for target>freq_sel (slow-down), go MONITOR->F_SWITCH directly.
REQ-026 SHALL, on F_SWITCH entry, set freq_sel=target and sw_req=1, holding both stable until sw_ack is sampled high.
REQ-027 SHALL drop sw_req the cycle after ack; exit to DWELL after a speed-up or to V_DOWN after a slow-down.
REQ-028 SHALL ignore sw_ack while sw_req=0.
REQ-029 SHALL accept a sw_ack present in the first F_SWITCH cycle.
REQ-030 SHALL, on V_DOWN entry, set vdd_level=3-freq_sel, wait V_SETTLE cycles, then go to DWELL.
REQ-031 SHALL stay in DWELL for DWELL cycles, then return to MONITOR with the window and busy counters cleared.
REQ-032 SHALL latch target at the decision; force_en or force_level changes mid-transition SHALL NOT alter it.
REQ-033 SHALL never raise freq above the level supported by the present vdd_level: vdd_level >= 3-freq_sel at all times.

Reset
REQ-034 SHALL, on rst asserted in any state including mid-handshake, immediately force state MONITOR, freq_sel=0, vdd_level=3, sw_req=0, in_transition=0, util_last=0, and all counters to 0.
REQ-035 SHALL start the first window on the first clock after rst deasserts.

Verification
REQ-036 SHALL, with WINDOW=16, UP_TH=12, DN_TH=4, V_SETTLE=8, DWELL=32, busy=0 for 16 cycles from reset: F_SWITCH with freq_sel=1, sw_req=1; ack -> V_DOWN, vdd_level=2 after 8 cycles; DWELL 32; util_last=0.
REQ-037 SHALL, from freq_sel=2 with busy=1 for a full window: vdd_level=2 first, then freq_sel=1 exactly 8 cycles later; util_last=16.
REQ-038 SHALL, with busy count=8 (between thresholds): no transition, in_transition stays 0, util_last=8.
REQ-039 SHALL, with force_en=1, force_level=3 from freq_sel=0: single F_SWITCH to 3, then vdd_level=0; toggling force_level mid-transition has no effect.
REQ-040 SHALL, with sw_ack withheld 20 cycles: sw_req and freq_sel stay stable; rst mid-wait -> freq_sel=0, vdd_level=3, sw_req=0 immediately.
REQ-041 SHALL check every cycle, across all scenarios, that vdd_level >= 3-freq_sel.
